// File: rtl/vga_timing_pkg.sv
// Shared constants for the raster timing generator: standard mode timings
// (640x480@60 and 800x600@60), the sync polarity type and a total-length helper.
package vga_timing_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // 640x480@60, 25.175 MHz nominal pixel rate (25 MHz in practice)
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam sync_pol_e VGA640_H_POL = SYNC_ACTIVE_LOW;
    localparam sync_pol_e VGA640_V_POL = SYNC_ACTIVE_LOW;

    // 800x600@60, 40 MHz pixel rate
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam sync_pol_e SVGA800_H_POL = SYNC_ACTIVE_HIGH;
    localparam sync_pol_e SVGA800_V_POL = SYNC_ACTIVE_HIGH;

    // Total length of one axis (line or frame) in pixels or lines.
    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus registered sync and
// active-window flags. The flags are computed from the next count so they
// line up with the count on the same clock.
module vga_axis_counter #(
    parameter int W        = 10,
    parameter int ACTIVE   = 640,
    parameter int FP       = 16,
    parameter int SYNC     = 96,
    parameter int BP       = 48,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         sync,
    output logic         active
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;
    logic         sync_reg;
    logic         active_reg;
    logic         in_sync_next;
    logic         in_active_next;

    // Next position and window membership of that next position.
    always_comb begin
        wrap           = adv && (cnt_reg == LAST);
        cnt_next       = wrap ? '0 : cnt_reg + W'(1);
        in_sync_next   = (cnt_next >= SYNC_START) && (cnt_next < SYNC_END);
        in_active_next = (cnt_next < ACT_END);
    end

    // Counter and window flags advance together; reset parks on the last
    // position so the first advance lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= LAST;
            sync_reg   <= ~SYNC_POL;
            active_reg <= 1'b0;
        end else if (adv) begin
            cnt_reg    <= cnt_next;
            sync_reg   <= in_sync_next ? SYNC_POL : ~SYNC_POL;
            active_reg <= in_active_next;
        end
    end

    assign cnt    = cnt_reg;
    assign sync   = sync_reg;
    assign active = active_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing master: two chained axis counters (pixel -> line) stepped by a
// pixel clock enable, with registered syncs, data enable, coordinates and
// line/frame start strobes all describing the same pixel on the same clock.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int H_ACTIVE   = VGA640_H_ACTIVE,
    parameter int H_FP       = VGA640_H_FP,
    parameter int H_SYNC     = VGA640_H_SYNC,
    parameter int H_BP       = VGA640_H_BP,
    parameter int V_ACTIVE   = VGA640_V_ACTIVE,
    parameter int V_FP       = VGA640_V_FP,
    parameter int V_SYNC     = VGA640_V_SYNC,
    parameter int V_BP       = VGA640_V_BP,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam sync_pol_e H_POL = (H_SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;
    localparam sync_pol_e V_POL = (V_SYNC_POL != 0) ? SYNC_ACTIVE_HIGH : SYNC_ACTIVE_LOW;

    // Reject degenerate or oversized modes at elaboration.
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_width
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if (H_TOTAL > (2 ** COORD_W) || V_TOTAL > (2 ** COORD_W)) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
    end

    logic               h_wrap;
    logic               v_wrap;
    logic               h_sync;
    logic               v_sync;
    logic               h_active;
    logic               v_active;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               line_start_reg;
    logic               frame_start_reg;

    vga_axis_counter #(
        .W        (COORD_W),
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (H_POL == SYNC_ACTIVE_HIGH)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (pix_ce),
        .cnt    (h_cnt),
        .wrap   (h_wrap),
        .sync   (h_sync),
        .active (h_active)
    );

    // The line counter steps only when the pixel counter wraps, so vsync
    // changes on the same clock that x returns to 0.
    vga_axis_counter #(
        .W        (COORD_W),
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (V_POL == SYNC_ACTIVE_HIGH)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (h_wrap),
        .cnt    (v_cnt),
        .wrap   (v_wrap),
        .sync   (v_sync),
        .active (v_active)
    );

    // Start strobes: one clock wide, set on the clock the counters wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= h_wrap;
            frame_start_reg <= h_wrap && v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    // Frame counter steps alongside the frame_start strobe and wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= 16'd0;
        end else if (h_wrap && v_wrap) begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

    assign hsync       = h_sync;
    assign vsync       = v_sync;
    assign de          = h_active && v_active;
    assign x           = h_cnt;
    assign y           = v_cnt;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: one default 640x480 instance and one
// tiny mode with active-high syncs (15 x 8 raster, 120 pixels per frame).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_ce;

    always #10 clk = ~clk;

    // Default-mode DUT
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    // Small-mode DUT
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0] s_x, s_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .hsync(d_hs), .vsync(d_vs), .de(d_de), .x(d_x), .y(d_y),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    vga_timing_gen #(
        .COORD_W(4),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    typedef struct {
        int x; int y; bit hs; bit vs; bit de; bit ls; bit fs; int fc;
    } px_t;
    typedef struct { px_t d; px_t s; } exp_t;

    exp_t q[$];
    px_t  md, ms;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Raster model from the timing description: hand-derived window bounds.
    function automatic px_t step(input px_t c, input bit ce, input int ht, input int vt,
                                 input int hss, input int hse, input int vss, input int vse,
                                 input int ha, input int va, input bit hp, input bit vp);
        px_t n = c;
        n.ls = 1'b0;
        n.fs = 1'b0;
        if (ce) begin
            if (c.x == ht - 1) begin
                n.x  = 0;
                n.ls = 1'b1;
                if (c.y == vt - 1) begin
                    n.y  = 0;
                    n.fs = 1'b1;
                    n.fc = (c.fc + 1) % 65536;
                end else begin
                    n.y = c.y + 1;
                end
            end else begin
                n.x = c.x + 1;
            end
            n.hs = (n.x >= hss && n.x < hse) ? hp : !hp;
            n.vs = (n.y >= vss && n.y < vse) ? vp : !vp;
            n.de = (n.x < ha) && (n.y < va);
        end
        return n;
    endfunction

    function automatic px_t reset_px(input int ht, input int vt, input bit hp, input bit vp);
        px_t r;
        r.x = ht - 1; r.y = vt - 1; r.hs = !hp; r.vs = !vp;
        r.de = 1'b0; r.ls = 1'b0; r.fs = 1'b0; r.fc = 0;
        return r;
    endfunction

    task automatic reset_models();
        md = reset_px(800, 525, 1'b0, 1'b0);
        ms = reset_px(15, 8, 1'b1, 1'b1);
    endtask

    // One stimulus clock: drive pix_ce, advance the models, queue the expectation.
    task automatic run_cycle(input bit ce);
        exp_t e;
        pix_ce = ce;
        @(posedge clk);
        #1;
        md = step(md, ce, 800, 525, 656, 752, 490, 492, 640, 480, 1'b0, 1'b0);
        ms = step(ms, ce, 15, 8, 10, 13, 5, 7, 8, 4, 1'b1, 1'b1);
        e.d = md;
        e.s = ms;
        q.push_back(e);
    endtask

    // Monitor: pop one expectation per presented pixel and compare all outputs.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("d_x", int'(d_x), e.d.x);
            check("d_y", int'(d_y), e.d.y);
            check("d_hsync", int'(d_hs), int'(e.d.hs));
            check("d_vsync", int'(d_vs), int'(e.d.vs));
            check("d_de", int'(d_de), int'(e.d.de));
            check("d_line_start", int'(d_ls), int'(e.d.ls));
            check("d_frame_start", int'(d_fs), int'(e.d.fs));
            check("s_x", int'(s_x), e.s.x);
            check("s_y", int'(s_y), e.s.y);
            check("s_hsync", int'(s_hs), int'(e.s.hs));
            check("s_vsync", int'(s_vs), int'(e.s.vs));
            check("s_de", int'(s_de), int'(e.s.de));
            check("s_line_start", int'(s_ls), int'(e.s.ls));
            check("s_frame_start", int'(s_fs), int'(e.s.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("d_frame_cnt", int'(d_fc), e.d.fc);
            check("s_frame_cnt", int'(s_fc), e.s.fc);
`endif
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_d_x"}, int'(d_x), 799);
        check({tag, "_d_y"}, int'(d_y), 524);
        check({tag, "_d_hsync"}, int'(d_hs), 1);
        check({tag, "_d_vsync"}, int'(d_vs), 1);
        check({tag, "_d_de"}, int'(d_de), 0);
        check({tag, "_d_ls"}, int'(d_ls), 0);
        check({tag, "_d_fs"}, int'(d_fs), 0);
        check({tag, "_s_x"}, int'(s_x), 14);
        check({tag, "_s_y"}, int'(s_y), 7);
        check({tag, "_s_hsync"}, int'(s_hs), 0);
        check({tag, "_s_vsync"}, int'(s_vs), 0);
        check({tag, "_s_de"}, int'(s_de), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        check({tag, "_s_fc"}, int'(s_fc), 0);
`endif
    endtask

    task automatic check_first_pixel(input string tag);
        @(negedge clk);
        #1;
        check({tag, "_d_x"}, int'(d_x), 0);
        check({tag, "_d_y"}, int'(d_y), 0);
        check({tag, "_d_de"}, int'(d_de), 1);
        check({tag, "_d_fs"}, int'(d_fs), 1);
        check({tag, "_d_ls"}, int'(d_ls), 1);
        check({tag, "_s_fs"}, int'(s_fs), 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        reset_models();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous pixel rate: two full lines of the default mode and
        // fourteen frames of the small mode.
        run_cycle(1'b1);
        check_first_pixel("first");
        for (int i = 0; i < 1700; i++) run_cycle(1'b1);

        // Half pixel rate: outputs hold and strobes stay one clock wide.
        for (int i = 0; i < 600; i++) run_cycle(i[0] ? 1'b0 : 1'b1);

        // Advance to x=300 of the default mode, then reset mid-cycle.
        for (int i = 0; i < 2000 && md.x != 300; i++) run_cycle(1'b1);
        check("reach_x300", md.x, 300);
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        pix_ce = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        reset_models();
        run_cycle(1'b1);
        check_first_pixel("after_reset");
        for (int i = 0; i < 400; i++) run_cycle(1'b1);

`ifdef VGA_TIMING_FRAME_CNT_EN
        // Preload the small-mode frame counter to its maximum and watch it wrap.
        @(negedge clk);
        #1;
        force dut_s.frame_cnt_reg = 16'hFFFF;
        #1;
        release dut_s.frame_cnt_reg;
        ms.fc = 65535;
        for (int i = 0; i < 130; i++) run_cycle(1'b1);
`endif

        @(negedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
